// File: rtl/rf_write_queue_pkg.sv
// rtl/rf_write_queue_pkg.sv - shared constants and entry type for the RF write queue
package rf_write_queue_pkg;

  localparam int DEF_DEPTH = 4;
  localparam int DW        = 16;
  localparam int AW        = 3;
  localparam int PTR_W     = $clog2(DEF_DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  typedef struct packed {
    logic [AW-1:0] regsel;
    logic [DW-1:0] data;
  } entry_t;

endpackage

// File: rtl/rf_write_queue_if.sv
// rtl/rf_write_queue_if.sv - producer, RF write port and lookup signals of the RF write queue
interface rf_write_queue_if
  import rf_write_queue_pkg::*;
#(
  parameter int CW = CNT_W
) ();

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_regsel;
  logic [DW-1:0] in_data;
  logic          wr_hold;
  logic          write;
  logic [AW-1:0] writeregsel;
  logic [DW-1:0] writedata;
  logic [AW-1:0] look1sel;
  logic [AW-1:0] look2sel;
  logic          look1hit;
  logic          look2hit;
  logic [DW-1:0] look1data;
  logic [DW-1:0] look2data;
  logic [CW-1:0] count;
  logic          err;

  // Environment side: producer, RF and decode stage
  modport master (
    output in_valid, in_regsel, in_data, wr_hold, look1sel, look2sel,
    input  in_ready, write, writeregsel, writedata,
    input  look1hit, look2hit, look1data, look2data, count, err
  );

  // Queue side
  modport slave (
    input  in_valid, in_regsel, in_data, wr_hold, look1sel, look2sel,
    output in_ready, write, writeregsel, writedata,
    output look1hit, look2hit, look1data, look2data, count, err
  );

endinterface

// File: rtl/rf_write_queue_match.sv
// rtl/rf_write_queue_match.sv - youngest-first register match over the occupied queue entries
module rf_write_queue_match
  import rf_write_queue_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  entry_t [DEPTH-1:0] i_entries,
  input  logic   [PW-1:0]    i_head,
  input  logic   [CW-1:0]    i_count,
  input  logic   [AW-1:0]    i_sel,
  output logic               o_hit,
  output logic   [DW-1:0]    o_data
);

  logic [PW-1:0] w_idx;

  // Walk occupied slots oldest to youngest; a later match overrides, so the youngest wins
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = i_head + PW'(k);
      if ((CW'(k) < i_count) && (i_entries[w_idx].regsel == i_sel)) begin
        o_hit  = 1'b1;
        o_data = i_entries[w_idx].data;
      end
    end
  end

endmodule

// File: rtl/rf_write_queue.sv
// rtl/rf_write_queue.sv - FIFO of pending RF writes draining into the RF write port; lookup under RF_WRITE_QUEUE_LOOKUP_EN
module rf_write_queue
  import rf_write_queue_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input logic             i_clk,
  input logic             i_rst,
  rf_write_queue_if.slave io_bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t [DEPTH-1:0] r_mem;
  logic   [PW-1:0]    r_head;
  logic   [PW-1:0]    r_tail;
  logic   [CW-1:0]    r_count;
  logic               r_err;

  logic   w_nonempty;
  logic   w_in_ready;
  logic   w_push;
  logic   w_pop;
  logic   w_overflow;
  entry_t w_in_entry;
  entry_t w_head_entry;

  assign w_nonempty   = (r_count != '0);
  // Acceptance depends only on fullness, never on a same-cycle pop
  assign w_in_ready   = (r_count < CW'(DEPTH));
  assign w_push       = io_bus.in_valid && w_in_ready;
  assign w_pop        = w_nonempty && !io_bus.wr_hold;
  assign w_overflow   = io_bus.in_valid && !w_in_ready;
  assign w_in_entry   = '{regsel: io_bus.in_regsel, data: io_bus.in_data};
  assign w_head_entry = w_nonempty ? r_mem[r_head] : '0;

  // Pointer, occupancy, storage and sticky-overflow update
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= w_in_entry;
        r_tail        <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
      if (w_overflow) begin
        r_err <= 1'b1;
      end
    end
  end

  assign io_bus.in_ready    = w_in_ready;
  assign io_bus.write       = w_pop;
  assign io_bus.writeregsel = w_head_entry.regsel;
  assign io_bus.writedata   = w_head_entry.data;
  assign io_bus.count       = r_count;
  assign io_bus.err         = r_err;

`ifdef RF_WRITE_QUEUE_LOOKUP_EN
  rf_write_queue_match #(
    .DEPTH (DEPTH)
  ) u_match1 (
    .i_entries (r_mem),
    .i_head    (r_head),
    .i_count   (r_count),
    .i_sel     (io_bus.look1sel),
    .o_hit     (io_bus.look1hit),
    .o_data    (io_bus.look1data)
  );

  rf_write_queue_match #(
    .DEPTH (DEPTH)
  ) u_match2 (
    .i_entries (r_mem),
    .i_head    (r_head),
    .i_count   (r_count),
    .i_sel     (io_bus.look2sel),
    .o_hit     (io_bus.look2hit),
    .o_data    (io_bus.look2data)
  );
`else
  // Lookup removed: ports kept and held at zero, selects ignored
  logic w_unused_look;
  assign w_unused_look    = ^{io_bus.look1sel, io_bus.look2sel};
  assign io_bus.look1hit  = 1'b0;
  assign io_bus.look2hit  = 1'b0;
  assign io_bus.look1data = '0;
  assign io_bus.look2data = '0;
`endif

endmodule

// File: tb/tb_rf_write_queue.sv
// tb/tb_rf_write_queue.sv - self-checking bench for rf_write_queue (lookup expectations follow RF_WRITE_QUEUE_LOOKUP_EN)
module tb_rf_write_queue;
  import rf_write_queue_pkg::*;

  localparam int DEPTH = DEF_DEPTH;
`ifdef RF_WRITE_QUEUE_LOOKUP_EN
  localparam bit LOOK_EN = 1'b1;
`else
  localparam bit LOOK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // Reference model: pending writes in FIFO order, plus written-value logs
  logic [18:0] m_q[$];
  logic [18:0] m_log[$];
  logic [18:0] d_log[$];
  bit          m_err = 1'b0;

  rf_write_queue_if bus ();

  rf_write_queue dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] m_look(input logic [2:0] sel);
    logic [16:0] r;
    r = '0;
    if (LOOK_EN) begin
      for (int i = m_q.size() - 1; i >= 0; i--) begin
        if (m_q[i][18:16] == sel) begin
          r = {1'b1, m_q[i][15:0]};
          break;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [58:0] expv();
    logic [18:0] head;
    logic        w;
    head = (m_q.size() != 0) ? m_q[0] : 19'd0;
    w    = (m_q.size() != 0) && !bus.wr_hold;
    return {w, head, 3'(m_q.size()), m_err, (m_q.size() < DEPTH),
            m_look(bus.look1sel), m_look(bus.look2sel)};
  endfunction

  function automatic logic [58:0] obs();
    return {bus.write, bus.writeregsel, bus.writedata, bus.count, bus.err, bus.in_ready,
            bus.look1hit, bus.look1data, bus.look2hit, bus.look2data};
  endfunction

  task automatic drive(input bit v, input logic [2:0] rs, input logic [15:0] d,
                       input bit h, input logic [2:0] s1, input logic [2:0] s2);
    bus.in_valid  = v;
    bus.in_regsel = rs;
    bus.in_data   = d;
    bus.wr_hold   = h;
    bus.look1sel  = s1;
    bus.look2sel  = s2;
    #1;
  endtask

  task automatic tick();
    int sz;
    @(negedge clk);
    if (bus.write === 1'b1) d_log.push_back({bus.writeregsel, bus.writedata});
    sz = m_q.size();
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_err = 1'b0;
    end else begin
      if (bus.in_valid && sz >= DEPTH) m_err = 1'b1;
      if (sz != 0 && !bus.wr_hold) m_log.push_back(m_q.pop_front());
      if (bus.in_valid && sz < DEPTH) m_q.push_back({bus.in_regsel, bus.in_data});
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (bus.write !== 1'b0) begin errors++; $display("FAIL reset_write: got %0b want 0", bus.write); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", bus.err); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
    checks++; if ({bus.writeregsel, bus.writedata} !== 19'd0) begin errors++; $display("FAIL reset_wport: got %h want 0", {bus.writeregsel, bus.writedata}); end
    checks++; if ({bus.look1hit, bus.look1data, bus.look2hit, bus.look2data} !== 34'd0) begin errors++; $display("FAIL reset_look: got %h want 0", {bus.look1hit, bus.look1data, bus.look2hit, bus.look2data}); end
  endtask

  task automatic test_single();
    drive(1, 3'd3, 16'h1234, 0, 0, 0);
    checks++; if (bus.write !== 1'b0) begin errors++; $display("FAIL single_no_early_write: got %0b want 0", bus.write); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (bus.write !== 1'b1) begin errors++; $display("FAIL single_write: got %0b want 1", bus.write); end
    checks++; if (bus.writeregsel !== 3'd3) begin errors++; $display("FAIL single_regsel: got %0d want 3", bus.writeregsel); end
    checks++; if (bus.writedata !== 16'h1234) begin errors++; $display("FAIL single_data: got %h want 1234", bus.writedata); end
    tick();
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL single_drained_count: got %0d want 0", bus.count); end
    checks++; if (bus.write !== 1'b0) begin errors++; $display("FAIL single_drained_write: got %0b want 0", bus.write); end
  endtask

  task automatic test_overflow();
    logic [18:0] pushed[4];
    for (int i = 0; i < 4; i++) begin
      pushed[i] = {3'($urandom), 16'($urandom)};
      drive(1, pushed[i][18:16], pushed[i][15:0], 1, 0, 0);
      tick();
    end
    drive(0, 0, 0, 1, 0, 0);
    checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL ovf_full_count: got %0d want 4", bus.count); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL ovf_in_ready: got %0b want 0", bus.in_ready); end
    drive(1, 3'd7, 16'hDEAD, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL ovf_err: got %0b want 1", bus.err); end
    checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL ovf_dropped_count: got %0d want 4", bus.count); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus.write, bus.writeregsel, bus.writedata} !== {1'b1, pushed[i]}) begin
        errors++; $display("FAIL ovf_drain%0d: got %h want %h", i, {bus.write, bus.writeregsel, bus.writedata}, {1'b1, pushed[i]});
      end
      tick();
    end
    checks++; if (bus.count !== 3'd0 || bus.write !== 1'b0) begin errors++; $display("FAIL ovf_empty: got count %0d write %0b want 0 0", bus.count, bus.write); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL ovf_err_sticky: got %0b want 1", bus.err); end
  endtask

  task automatic test_lookup();
    drive(1, 3'd5, 16'h0001, 1, 3'd5, 3'd6);
    checks++; if (bus.look1hit !== 1'b0) begin errors++; $display("FAIL look_inflight_hidden: got %0b want 0", bus.look1hit); end
    tick();
    drive(1, 3'd5, 16'h0002, 1, 3'd5, 3'd6);
    checks++; if ({bus.look1hit, bus.look1data} !== (LOOK_EN ? 17'h10001 : 17'h0)) begin errors++; $display("FAIL look_first: got %h want %h", {bus.look1hit, bus.look1data}, (LOOK_EN ? 17'h10001 : 17'h0)); end
    tick();
    drive(0, 0, 0, 1, 3'd5, 3'd6);
    checks++; if ({bus.look1hit, bus.look1data} !== (LOOK_EN ? 17'h10002 : 17'h0)) begin errors++; $display("FAIL look_youngest: got %h want %h", {bus.look1hit, bus.look1data}, (LOOK_EN ? 17'h10002 : 17'h0)); end
    checks++; if ({bus.look2hit, bus.look2data} !== 17'h0) begin errors++; $display("FAIL look_miss: got %h want 0", {bus.look2hit, bus.look2data}); end
    drive(0, 0, 0, 0, 3'd5, 3'd6);
    tick();
    checks++; if ({bus.look1hit, bus.look1data} !== (LOOK_EN ? 17'h10002 : 17'h0)) begin errors++; $display("FAIL look_after_pop1: got %h want %h", {bus.look1hit, bus.look1data}, (LOOK_EN ? 17'h10002 : 17'h0)); end
    tick();
    checks++; if ({bus.look1hit, bus.look1data} !== 17'h0) begin errors++; $display("FAIL look_after_pop2: got %h want 0", {bus.look1hit, bus.look1data}); end
  endtask

  task automatic test_back_to_back();
    logic [18:0] pushed[$];
    logic [18:0] e;
    d_log.delete();
    for (int i = 0; i < 2; i++) begin
      e = {3'($urandom), 16'($urandom)};
      pushed.push_back(e);
      drive(1, e[18:16], e[15:0], 1, 0, 0);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      e = {3'($urandom), 16'($urandom)};
      pushed.push_back(e);
      drive(1, e[18:16], e[15:0], 0, 3'($urandom), 3'($urandom));
      checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL b2b_count%0d: got %0d want 2", i, bus.count); end
      checks++; if (obs() !== expv()) begin errors++; $display("FAIL b2b_outputs%0d: got %h want %h", i, obs(), expv()); end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    checks++; if (d_log.size() != pushed.size()) begin errors++; $display("FAIL b2b_write_count: got %0d want %0d", d_log.size(), pushed.size()); end
    for (int i = 0; i < pushed.size() && i < d_log.size(); i++) begin
      checks++; if (d_log[i] !== pushed[i]) begin errors++; $display("FAIL b2b_order%0d: got %h want %h", i, d_log[i], pushed[i]); end
    end
  endtask

  task automatic test_random();
    m_log.delete();
    d_log.delete();
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 99) < 60, 3'($urandom), 16'($urandom),
            $urandom_range(0, 99) < 35, 3'($urandom), 3'($urandom));
      checks++; if (obs() !== expv()) begin errors++; $display("FAIL rand_outputs%0d: got %h want %h", i, obs(), expv()); end
      tick();
    end
    checks++; if (d_log.size() != m_log.size()) begin errors++; $display("FAIL rand_write_count: got %0d want %0d", d_log.size(), m_log.size()); end
    for (int i = 0; i < m_log.size() && i < d_log.size(); i++) begin
      checks++; if (d_log[i] !== m_log[i]) begin errors++; $display("FAIL rand_stream%0d: got %h want %h", i, d_log[i], m_log[i]); end
    end
  endtask

  task automatic test_reset_midflight();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 3'($urandom), 16'($urandom), 1, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 0, 0);
    checks++; if (bus.count !== 3'd3 || bus.err !== 1'b1) begin errors++; $display("FAIL mid_setup: got count %0d err %0b want 3 1", bus.count, bus.err); end
    d_log.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", bus.count); end
    checks++; if (bus.write !== 1'b0) begin errors++; $display("FAIL mid_write: got %0b want 0", bus.write); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL mid_err: got %0b want 0", bus.err); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %0b want 1", bus.in_ready); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (d_log.size() != 0) begin errors++; $display("FAIL mid_stale_writes: got %0d want 0", d_log.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_lookup();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
